// File: rtl/tm1638_pkg.sv
// Shared types and constants for the TM1638 display/key controller.
// Command words are {kind, data, command} and are pushed to an external SPI FIFO.
package tm1638_pkg;

  typedef enum logic [1:0] {
    ST_INIT_MODE,
    ST_INIT_CTRL,
    ST_IDLE,
    ST_KEY_WAIT
  } state_e;

  typedef enum logic [1:0] {
    KIND_CMD   = 2'b00,
    KIND_WRITE = 2'b01,
    KIND_READ  = 2'b10,
    KIND_RSVD  = 2'b11
  } kind_e;

  localparam int WORD_W  = 18;
  localparam int NUM_SEG = 16;

  localparam logic [7:0] CMD_MODE_FIXED = 8'h44;
  localparam logic [7:0] CMD_CTRL       = 8'h80;
  localparam logic [7:0] CMD_READ_KEYS  = 8'h42;
  localparam logic [7:0] CMD_ADDR       = 8'hC0;

  function automatic logic [WORD_W-1:0] pack_word(kind_e kind, logic [7:0] data,
                                                  logic [7:0] cmd);
    return {kind, data, cmd};
  endfunction

  function automatic logic [7:0] ctrl_cmd(logic disp_on, logic [2:0] bright);
    return CMD_CTRL | {4'b0000, disp_on, bright};
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Round-robin picker: lowest set bit of a 16-bit mask at or after ptr,
// wrapping from 15 back to 0.
module rr_pick16 (
  input  logic [15:0] i_mask,
  input  logic [3:0]  i_ptr,
  output logic [3:0]  o_idx,
  output logic        o_found
);

  logic [31:0] dbl;
  logic [15:0] rot;
  logic [3:0]  ofs;

  always_comb begin
    // Rotating right by ptr turns "first at or after ptr" into "first from bit 0".
    dbl = {i_mask, i_mask} >> i_ptr;
    rot = dbl[15:0];
    ofs = '0;
    for (int i = 15; i >= 0; i--) begin
      if (rot[i]) ofs = 4'(i);
    end
    o_idx   = i_ptr + ofs;
    o_found = |i_mask;
  end

endmodule

// File: rtl/tm1638_ctrl.sv
// TM1638 controller: keeps a 16-byte segment shadow, schedules init, control,
// key-scan and dirty-segment command words into an SPI FIFO, and samples keys.
module tm1638_ctrl
  import tm1638_pkg::*;
#(
  parameter int KEY_PERIOD = 250000,
  parameter int KEY_WAIT   = 400,
  parameter int READ_WIDTH = 32
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Seg_Wr,
  input  logic [3:0]            i_Seg_Addr,
  input  logic [7:0]            i_Seg_Data,
  input  logic [2:0]            i_Bright,
  input  logic                  i_Disp_On,
  input  logic                  i_FIFO_Full,
  output logic                  o_Data_Valid,
  output logic [WORD_W-1:0]     o_Data,
  input  logic [READ_WIDTH-1:0] i_Key_Data,
  output logic [READ_WIDTH-1:0] o_Keys,
  output logic                  o_Keys_Valid,
  output logic                  o_Busy
);

  localparam int KP_W = (KEY_PERIOD > 1) ? $clog2(KEY_PERIOD) : 1;
  localparam int KW_W = (KEY_WAIT > 1) ? $clog2(KEY_WAIT) : 1;
  localparam logic [KP_W-1:0] KP_LAST = KP_W'(KEY_PERIOD - 1);
  localparam logic [KW_W-1:0] KW_LAST = KW_W'(KEY_WAIT - 1);

  state_e                  state_q, state_d;
  logic [7:0]              shadow_q [NUM_SEG];
  logic [7:0]              shadow_d [NUM_SEG];
  logic [NUM_SEG-1:0]      dirty_q, dirty_d;
  logic [3:0]              ptr_q, ptr_d;
  logic [KP_W-1:0]         key_cnt_q, key_cnt_d;
  logic                    due_q, due_d;
  logic [2:0]              rec_bright_q, rec_bright_d;
  logic                    rec_on_q, rec_on_d;
  logic [KW_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic                    data_valid_q, data_valid_d;
  logic [WORD_W-1:0]       data_q, data_d;
  logic [READ_WIDTH-1:0]   keys_q, keys_d;
  logic                    keys_valid_q, keys_valid_d;

  logic [NUM_SEG-1:0]      seg_clear;
  logic                    can_push;
  logic                    ctrl_diff;
  logic                    key_wrap;
  logic                    scan_push;
  logic [WORD_W-1:0]       ctrl_word;
  logic [3:0]              pick_idx;
  logic                    pick_found;

  rr_pick16 u_pick (
    .i_mask  (dirty_q),
    .i_ptr   (ptr_q),
    .o_idx   (pick_idx),
    .o_found (pick_found)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    shadow_d     = shadow_q;
    ptr_d        = ptr_q;
    rec_bright_d = rec_bright_q;
    rec_on_d     = rec_on_q;
    wait_cnt_d   = wait_cnt_q;
    data_valid_d = 1'b0;
    data_d       = data_q;
    keys_d       = keys_q;
    keys_valid_d = 1'b0;
    scan_push    = 1'b0;
    seg_clear    = '0;

    // The cooldown cycle after each push lets the FIFO full flag catch up.
    can_push  = !data_valid_q && !i_FIFO_Full;
    ctrl_diff = (i_Bright != rec_bright_q) || (i_Disp_On != rec_on_q);
    ctrl_word = pack_word(KIND_CMD, 8'h00, ctrl_cmd(i_Disp_On, i_Bright));
    key_wrap  = (key_cnt_q == KP_LAST);
    key_cnt_d = key_wrap ? '0 : key_cnt_q + KP_W'(1);

    case (state_q)
      ST_INIT_MODE: begin
        if (can_push) begin
          data_valid_d = 1'b1;
          data_d       = pack_word(KIND_CMD, 8'h00, CMD_MODE_FIXED);
          state_d      = ST_INIT_CTRL;
        end
      end
      ST_INIT_CTRL: begin
        if (can_push) begin
          data_valid_d = 1'b1;
          data_d       = ctrl_word;
          rec_bright_d = i_Bright;
          rec_on_d     = i_Disp_On;
          state_d      = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (can_push) begin
          if (ctrl_diff) begin
            data_valid_d = 1'b1;
            data_d       = ctrl_word;
            rec_bright_d = i_Bright;
            rec_on_d     = i_Disp_On;
          end else if (due_q) begin
            data_valid_d = 1'b1;
            data_d       = pack_word(KIND_READ, 8'h00, CMD_READ_KEYS);
            scan_push    = 1'b1;
            wait_cnt_d   = '0;
            state_d      = ST_KEY_WAIT;
          end else if (pick_found && !i_Seg_Wr) begin
            // Segment service waits out a write burst so back-to-back updates
            // to one digit coalesce into a single transfer.
            data_valid_d        = 1'b1;
            data_d              = pack_word(KIND_WRITE, shadow_q[pick_idx],
                                            CMD_ADDR | {4'b0000, pick_idx});
            seg_clear[pick_idx] = 1'b1;
            ptr_d               = pick_idx + 4'd1;
          end
        end
      end
      ST_KEY_WAIT: begin
        if (wait_cnt_q == KW_LAST) begin
          keys_d       = i_Key_Data;
          keys_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + KW_W'(1);
        end
      end
      default: state_d = ST_INIT_MODE;
    endcase

    // A wrap while already due stays a single pending scan.
    due_d = key_wrap ? 1'b1 : (scan_push ? 1'b0 : due_q);

    // Clear first, then apply the write, so a same-cycle write keeps dirty set.
    dirty_d = dirty_q & ~seg_clear;
    if (i_Seg_Wr) begin
      shadow_d[i_Seg_Addr] = i_Seg_Data;
      dirty_d[i_Seg_Addr]  = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= ST_INIT_MODE;
      // NOTE: the shadow is reset because the all-dirty reset state blanks the
      // display from it; a RAM without reset would push garbage digits.
      shadow_q     <= '{default: '0};
      dirty_q      <= '1;
      ptr_q        <= '0;
      key_cnt_q    <= '0;
      due_q        <= 1'b0;
      rec_bright_q <= '0;
      rec_on_q     <= 1'b0;
      wait_cnt_q   <= '0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      keys_q       <= '0;
      keys_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      dirty_q      <= dirty_d;
      ptr_q        <= ptr_d;
      key_cnt_q    <= key_cnt_d;
      due_q        <= due_d;
      rec_bright_q <= rec_bright_d;
      rec_on_q     <= rec_on_d;
      wait_cnt_q   <= wait_cnt_d;
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
      keys_q       <= keys_d;
      keys_valid_q <= keys_valid_d;
    end
  end

  assign o_Data_Valid = data_valid_q;
  assign o_Data       = data_q;
  assign o_Keys       = keys_q;
  assign o_Keys_Valid = keys_valid_q;
  assign o_Busy       = (state_q != ST_IDLE) || (|dirty_q);

endmodule

// File: tb/tb_tm1638_ctrl.sv
// Self-checking bench for tm1638_ctrl: a cycle-level behavioural model is
// compared every cycle, with directed literal checks pinning the model.
module tb_tm1638_ctrl;

  localparam int KP = 50;
  localparam int KW = 10;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          seg_wr = 1'b0;
  logic [3:0]    seg_addr = '0;
  logic [7:0]    seg_data = '0;
  logic [2:0]    bright = 3'd3;
  logic          disp_on = 1'b1;
  logic          fifo_full = 1'b0;
  logic          data_valid;
  logic [17:0]   data;
  logic [RW-1:0] key_data = 32'hA5A5_0001;
  logic [RW-1:0] keys;
  logic          keys_valid;
  logic          busy;

  tm1638_ctrl #(.KEY_PERIOD(KP), .KEY_WAIT(KW), .READ_WIDTH(RW)) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Seg_Wr     (seg_wr),
    .i_Seg_Addr   (seg_addr),
    .i_Seg_Data   (seg_data),
    .i_Bright     (bright),
    .i_Disp_On    (disp_on),
    .i_FIFO_Full  (fifo_full),
    .o_Data_Valid (data_valid),
    .o_Data       (data),
    .i_Key_Data   (key_data),
    .o_Keys       (keys),
    .o_Keys_Valid (keys_valid),
    .o_Busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [17:0] seen[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase;      // 0 mode word, 1 control word, 2 idle, 3 awaiting keys
  int          m_edge;       // clock edges since reset release
  int          m_deadline;
  bit          m_due;
  bit [2:0]    m_bright;
  bit          m_on;
  bit [7:0]    m_shadow[16];
  bit          m_dirty[16];
  int          m_ptr;
  bit          m_valid;
  bit [17:0]   m_data;
  bit [RW-1:0] m_keys;
  bit          m_kv;

  task automatic model_reset();
    m_phase = 0; m_edge = 0; m_deadline = 0; m_due = 0;
    m_bright = 0; m_on = 0; m_ptr = 0;
    m_valid = 0; m_data = 0; m_keys = 0; m_kv = 0;
    for (int i = 0; i < 16; i++) begin
      m_shadow[i] = 8'h00;
      m_dirty[i]  = 1'b1;
    end
  endtask

  task automatic model_step();
    bit        push, scan, kv;
    bit [17:0] w;
    int        pick;
    m_edge++;
    push = 0; scan = 0; kv = 0; pick = -1; w = m_data;
    if (m_phase == 0) begin
      if (!m_valid && !fifo_full) begin push = 1; w = 18'h00044; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (!m_valid && !fifo_full) begin
        push = 1; w = {2'b00, 8'h00, 8'h80 | {4'h0, disp_on, bright}};
        m_bright = bright; m_on = disp_on; m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (!m_valid && !fifo_full) begin
        if (bright != m_bright || disp_on != m_on) begin
          push = 1; w = {2'b00, 8'h00, 8'h80 | {4'h0, disp_on, bright}};
          m_bright = bright; m_on = disp_on;
        end else if (m_due) begin
          push = 1; scan = 1; w = 18'h20042;
          m_phase = 3; m_deadline = m_edge + KW;
        end else if (!seg_wr) begin
          for (int k = 0; k < 16; k++)
            if (pick < 0 && m_dirty[(m_ptr + k) % 16]) pick = (m_ptr + k) % 16;
          if (pick >= 0) begin
            push = 1; w = {2'b01, m_shadow[pick], 8'(8'hC0 + pick)};
            m_dirty[pick] = 0; m_ptr = (pick + 1) % 16;
          end
        end
      end
    end else begin
      if (m_edge == m_deadline) begin m_keys = key_data; kv = 1; m_phase = 2; end
    end
    if (m_edge % KP == 0) m_due = 1;
    else if (scan)        m_due = 0;
    if (seg_wr) begin
      m_shadow[seg_addr] = seg_data;
      m_dirty[seg_addr]  = 1;
    end
    m_valid = push;
    if (push) m_data = w;
    m_kv = kv;
  endtask

  function automatic bit model_busy();
    bit any = 0;
    for (int i = 0; i < 16; i++) any |= m_dirty[i];
    return (m_phase != 2) || any;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(posedge clk) cyc++;

  // Compare process and word monitor, away from the active edge.
  always @(negedge clk) begin
    check("valid", data_valid, m_valid);
    if (m_valid || !rst_n) check("data", data, m_data);
    check("keys_valid", keys_valid, m_kv);
    check("keys", keys, m_keys);
    check("busy", busy, model_busy());
    if (data_valid) seen.push_back(data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic seg_write(input logic [3:0] a, input logic [7:0] d);
    seg_wr = 1'b1; seg_addr = a; seg_data = d;
    tick();
    seg_wr = 1'b0;
  endtask

  function automatic logic [17:0] seen_at(int i);
    return (i < seen.size()) ? seen[i] : 18'h3FFFF;
  endfunction

  task automatic check_init(string tag);
    check({tag, "_count"}, seen.size(), 18);
    check({tag, "_mode"}, seen_at(0), 18'h00044);
    check({tag, "_ctrl"}, seen_at(1), 18'h0008B);
    for (int i = 0; i < 16; i++)
      check({tag, "_blank"}, seen_at(2 + i), 18'h100C0 + 18'(i));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          found;
    int          t0, t1, nseg;
    logic [17:0] segs[$];
    model_reset();

    // Reset state and init sequence
    repeat (3) tick();
    check("rst_busy", busy, 1);
    check("rst_valid", data_valid, 0);
    check("rst_keys", keys, 0);
    seen.delete();
    rst_n = 1'b1;
    repeat (40) tick();
    check_init("init");

    // FIFO held full with addresses 2 and 9 dirty
    fifo_full = 1'b1;
    seg_write(4'd2, 8'h11);
    seg_write(4'd9, 8'h99);
    seen.delete();
    repeat (100) tick();
    check("full_no_push", seen.size(), 0);
    fifo_full = 1'b0;
    repeat (60) tick();
    segs.delete();
    foreach (seen[i]) if (seen[i][17:16] == 2'b01) segs.push_back(seen[i]);
    check("full_seg_count", segs.size(), 2);
    check("full_seg_first", segs.size() > 0 ? segs[0] : 18'h3FFFF, 18'h111C2);
    check("full_seg_second", segs.size() > 1 ? segs[1] : 18'h3FFFF, 18'h199C9);

    // Back-to-back writes to one address coalesce
    seen.delete();
    seg_write(4'd5, 8'h3F);
    seg_write(4'd5, 8'h06);
    repeat (24) tick();
    nseg = 0;
    foreach (seen[i]) if (seen[i][17:16] == 2'b01) begin
      nseg++;
      check("coalesce_word", seen[i], 18'h106C5);
    end
    check("coalesce_count", nseg, 1);

    // Key scan latency and sampled data
    key_data = 32'hA5A5_0001;
    found = 0; t0 = 0; t1 = 0;
    for (int t = 0; t < 120 && !found; t++) begin
      tick();
      if (data_valid && data == 18'h20042) begin found = 1; t0 = cyc; end
    end
    check("scan_push_seen", found, 1);
    found = 0;
    for (int t = 0; t < 30 && !found; t++) begin
      tick();
      if (keys_valid) begin found = 1; t1 = cyc; end
    end
    check("keys_valid_seen", found, 1);
    check("keys_latency", t1 - t0, KW);
    check("keys_value", keys, 32'hA5A5_0001);
    tick();
    check("keys_valid_single", keys_valid, 0);

    // Priority: control change > key scan > segments
    fifo_full = 1'b1;
    seg_write(4'd0, 8'h01);
    seg_write(4'd3, 8'h23);
    seg_write(4'd7, 8'h45);
    seg_write(4'd12, 8'h67);
    repeat (55) tick();
    bright = 3'd7;
    for (int t = 0; t < 60 && (m_edge % KP) != 5; t++) tick();
    seen.delete();
    fifo_full = 1'b0;
    repeat (40) tick();
    check("prio_ctrl", seen_at(0), 18'h0008F);
    check("prio_scan", seen_at(1), 18'h20042);
    for (int i = 0; i < 4; i++) check("prio_seg_kind", seen_at(2 + i) >> 16, 2'b01);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      seg_wr    = ($urandom_range(3) == 0);
      seg_addr  = 4'($urandom_range(15));
      seg_data  = 8'($urandom);
      fifo_full = ($urandom_range(2) == 0);
      key_data  = $urandom;
      if ($urandom_range(199) == 0) begin
        bright  = 3'($urandom_range(7));
        disp_on = 1'($urandom_range(1));
      end
      tick();
    end
    seg_wr = 1'b0; fifo_full = 1'b0;

    // Reset asserted while awaiting key data
    found = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      tick();
      if (m_phase == 3) found = 1;
    end
    check("wait_reached", found, 1);
    rst_n = 1'b0;
    #1;
    check("abort_keys", keys, 0);
    check("abort_valid", data_valid, 0);
    check("abort_busy", busy, 1);
    repeat (3) tick();
    bright = 3'd3; disp_on = 1'b1;
    seen.delete();
    rst_n = 1'b1;
    repeat (40) tick();
    check_init("reinit");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tm1638_ctrl.md
TM1638_CTRL -- requirements
Module: tm1638_ctrl

Interface
REQ-001 SHALL have parameter KEY_PERIOD, default 250000, meaning clocks between key-scan requests.
REQ-002 SHALL have parameter KEY_WAIT, default 400, meaning clocks from key-read push to result sampling.
REQ-003 SHALL have parameter READ_WIDTH, default 32, meaning key data width returned by the SPI/FIFO path.
REQ-004 SHALL have ports:
  i_Clk  in  1  the single clock; all logic on rising edge.
  i_Rst_n  in  1  reset; asynchronous, active-low.
  i_Seg_Wr  in  1  one-cycle segment write strobe.
  i_Seg_Addr  in  4  display register 0..15.
  i_Seg_Data  in  8  segment byte.
  i_Bright  in  3  brightness level.
  i_Disp_On  in  1  display enable.
  i_FIFO_Full  in  1  spi_fifo FIFO full.
  o_Data_Valid  out  1  one-cycle push strobe to spi_fifo.
  o_Data  out  18  command word, format per package.
  i_Key_Data  in  READ_WIDTH  spi_fifo read data.
  o_Keys  out  READ_WIDTH  last sampled key data.
  o_Keys_Valid  out  1  one-cycle pulse when o_Keys updates.
  o_Busy  out  1  high when not IDLE or any dirty bit set.

Function
REQ-005 Word format SHALL be [17:16] kind (00 cmd only, 01 cmd+data write, 10 cmd+read, 11 reserved, never issued), [15:8] data, [7:0] command.
REQ-006 SHALL hold a 16x8 shadow register plus 16 dirty bits; i_Seg_Wr writes shadow[i_Seg_Addr] and sets its dirty bit in the same cycle.
REQ-007 Repeated writes to a dirty address SHALL overwrite shadow; one transfer carries the latest value.
REQ-008 Write and scheduler dirty-clear on the same address in the same cycle SHALL leave dirty set (write wins).
REQ-009 States SHALL be INIT_MODE, INIT_CTRL, IDLE, KEY_WAIT; the state register SHALL be a package enum.
REQ-010 INIT_MODE SHALL push kind 00 cmd 0x44 (fixed address write); then INIT_CTRL SHALL push kind 00 cmd 0x80|(i_Disp_On<<3)|i_Bright, record sent brightness/on, go IDLE.
REQ-011 A push SHALL occur only in a cycle with i_FIFO_Full low; o_Data_Valid high exactly one cycle, o_Data stable that cycle; at most one push per two cycles (cooldown cycle after each push for full flag to update).
REQ-012 IDLE priority per push slot SHALL be: control change (i_Bright/i_Disp_On differs from recorded) > key scan due > dirty segment.
REQ-013 Control change SHALL push the INIT_CTRL word and update the record.
REQ-014 Key timer SHALL count 0..KEY_PERIOD-1 continuously and set a sticky due flag at wrap; a key scan pushes kind 10 cmd 0x42, clears due, enters KEY_WAIT.
REQ-015 KEY_WAIT SHALL count KEY_WAIT clocks, then load o_Keys from i_Key_Data, pulse o_Keys_Valid one cycle, return IDLE; no pushes occur in KEY_WAIT.
REQ-016 Dirty service SHALL pick lowest dirty index at or after a round-robin pointer (wrapping 15->0), push kind 01 cmd 0xC0|idx data shadow[idx], clear that dirty bit, set pointer to idx+1 mod 16.
REQ-017 A due flag set while already due SHALL remain single (no queued second scan).
REQ-018 If i_FIFO_Full stays high, the pending choice SHALL re-evaluate priority each cycle; no word dropped, none duplicated.

Reset
REQ-019 While i_Rst_n low: state INIT_MODE, o_Data_Valid 0, o_Data 0, o_Keys 0, o_Keys_Valid 0, shadow 0, dirty all 1 (blank display after init), pointer 0, key timer 0, due 0, recorded control 0, o_Busy 1.
REQ-020 Reset assertion mid-push or mid-KEY_WAIT SHALL abort immediately; release SHALL restart from INIT_MODE.

Structure
REQ-021 tm1638_pkg SHALL hold the state enum, kind codes, command constants 0x44, 0x80, 0x42, 0xC0 and a word-pack function.
REQ-022 The dirty picker (16-bit mask + pointer -> index, found) SHALL be one sub-module rr_pick16.

Verification
REQ-023 Release reset, FIFO never full -> pushes 0x00044, 0x00080|ctrl, then 16 writes 0x1_00C0..0x1_00CF data 0x00 in order.
REQ-024 After idle, write addr 5=0x3F then addr 5=0x06 back-to-back -> exactly one push 0x1_06C5.
REQ-025 Hold i_FIFO_Full high 100 cycles with addr 2,9 dirty -> no o_Data_Valid; on release 0x1xxC2 then 0x1xxC9.
REQ-026 KEY_PERIOD=50, KEY_WAIT=10, i_Key_Data=0xA5A5_0001 -> push 0x2_0042, 10 clocks later o_Keys=0xA5A50001 with one-cycle o_Keys_Valid.
REQ-027 Change i_Bright 3->7 while 4 segments dirty and scan due -> control word 0x0008F first, then key read, then segments.
REQ-028 Assert i_Rst_n low during KEY_WAIT -> o_Keys 0 asynchronously; after release, init sequence repeats per REQ-023.
